// File: rtl/ddr_lane_dly_ctrl.sv
// ddr_lane_dly_ctrl: multi-lane delay-line tap sequencer with clock-pause guard and per-lane tap tracking.
// Optional QUERY_LANE/TAP_POS readback when DDR_DLY_TAP_READBACK_EN is defined.
module ddr_lane_dly_ctrl #(
  parameter  int NUM_LANES    = 4,
  parameter  int TAP_W        = 8,
  parameter  int PAUSE_CYCLES = 2,
  parameter  int MOVE_GAP     = 1,
  localparam int LANE_W       = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [LANE_W-1:0]    CMD_LANE,
  input  logic [1:0]           CMD_OP,
  input  logic                 CMD_DIR,
  input  logic [TAP_W-1:0]     CMD_TAPS,
  output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
  output logic                 DONE,
  output logic                 ERR
`ifdef DDR_DLY_TAP_READBACK_EN
  ,
  input  logic [LANE_W-1:0]    QUERY_LANE,
  output logic [TAP_W-1:0]     TAP_POS
`endif
);
`ifdef DDR_DLY_TAP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [1:0] OP_MOVE = 2'b00, OP_LOAD = 2'b01, OP_QUERY = 2'b10, OP_RSVD = 2'b11;
  localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(MOVE_GAP - 1);
  typedef enum logic [2:0] {IDLE, PRE, SETUP, ACT, GAP, POST, FIN} state_t;
  state_t               st_q;
  logic [LANE_W-1:0]    lane_q;
  logic [1:0]           op_q;
  logic                 dir_q, abort_q, done_q, err_q;
  logic [TAP_W-1:0]     rem_q;
  logic [3:0]           cnt_q;
  logic [NUM_LANES-1:0] sel_q, load_q, dirn_q, move_q, pause_q;
  logic [TAP_W-1:0]     pos_q [NUM_LANES];
  logic [NUM_LANES-1:0] cmd_oh, lane_oh;
  logic [TAP_W-1:0]     cur_pos, pos_step;
  logic                 bad_cmd, oor_hit;
  assign cmd_oh  = NUM_LANES'(1) << CMD_LANE;
  assign lane_oh = NUM_LANES'(1) << lane_q;
  assign cur_pos = pos_q[lane_q];
  assign oor_hit = DELAY_LINE_OUT_OF_RANGE[lane_q];
  // tap position saturates at both ends; hitting a limit is not an error
  assign pos_step = dir_q ? (&cur_pos ? cur_pos : cur_pos + TAP_W'(1))
                          : (cur_pos == '0 ? cur_pos : cur_pos - TAP_W'(1));
  assign bad_cmd = ({1'b0, CMD_LANE} >= (LANE_W + 1)'(NUM_LANES)) || CMD_OP == OP_RSVD
                   || (CMD_OP == OP_QUERY && !RB);
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      st_q    <= IDLE;
      lane_q  <= '0;
      op_q    <= OP_MOVE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      load_q  <= '0;
      dirn_q  <= '0;
      move_q  <= '0;
      pause_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) pos_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      move_q <= '0;
      load_q <= '0;
      case (st_q)
        IDLE: if (CMD_VALID) begin
          lane_q  <= CMD_LANE;
          op_q    <= CMD_OP;
          dir_q   <= CMD_DIR;
          rem_q   <= CMD_TAPS;
          abort_q <= 1'b0;
          if (bad_cmd || CMD_OP == OP_QUERY || (CMD_OP == OP_MOVE && CMD_TAPS == '0)) begin
            st_q   <= FIN;
            done_q <= 1'b1;
            err_q  <= bad_cmd;
          end else begin
            st_q    <= PRE;
            pause_q <= cmd_oh;
            cnt_q   <= PAUSE_LAST;
          end
        end
        PRE: if (cnt_q == '0) begin
          st_q   <= SETUP;
          sel_q  <= lane_oh;
          dirn_q <= dir_q ? lane_oh : '0;
        end else cnt_q <= cnt_q - 4'd1;
        SETUP: begin
          st_q <= ACT;
          if (op_q == OP_LOAD) begin
            load_q         <= lane_oh;
            pos_q[lane_q]  <= rem_q;
          end else begin
            move_q        <= lane_oh;
            pos_q[lane_q] <= pos_step;
            rem_q         <= rem_q - TAP_W'(1);
          end
        end
        ACT: if (op_q == OP_LOAD) begin
          st_q   <= POST;
          sel_q  <= '0;
          dirn_q <= '0;
          cnt_q  <= PAUSE_LAST;
        end else begin
          st_q  <= GAP;
          cnt_q <= GAP_LAST;
        end
        GAP: if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
        else if (!oor_hit && rem_q != '0) begin
          st_q          <= ACT;
          move_q        <= lane_oh;
          pos_q[lane_q] <= pos_step;
          rem_q         <= rem_q - TAP_W'(1);
        end else begin
          st_q    <= POST;
          sel_q   <= '0;
          dirn_q  <= '0;
          cnt_q   <= PAUSE_LAST;
          abort_q <= oor_hit;
        end
        POST: if (cnt_q == '0) begin
          st_q    <= FIN;
          pause_q <= '0;
          done_q  <= 1'b1;
          err_q   <= abort_q;
        end else cnt_q <= cnt_q - 4'd1;
        default: st_q <= IDLE;
      endcase
    end
  end
`ifdef DDR_DLY_TAP_READBACK_EN
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) TAP_POS <= '0;
    else TAP_POS <= pos_q[QUERY_LANE];
  end
`endif
  assign CMD_READY            = st_q == IDLE;
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_DIRECTION = dirn_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign HS_IO_CLK_PAUSE      = pause_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// tb_ddr_lane_dly_ctrl: directed checks of the lane delay sequencer; readback checks only when
// DDR_DLY_TAP_READBACK_EN is defined.
module tb_ddr_lane_dly_ctrl;
  localparam int NL = 4;
`ifdef DDR_DLY_TAP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cv = 1'b0, cdir = 1'b0;
  logic [1:0] clane = '0, cop = '0;
  logic [7:0] ctaps = '0;
  logic rdy, done, err;
  logic [NL-1:0] sel, ld, dr, mv, pz, oor = '0;
  logic cv3 = 1'b0;
  logic [1:0] clane3 = '0;
  logic rdy3, done3, err3;
  logic [2:0] sel3, ld3, dr3, mv3, pz3;
`ifdef DDR_DLY_TAP_READBACK_EN
  logic [1:0] ql = '0, ql3 = '0;
  logic [7:0] tp, tp3;
`endif
  int total = 0, bad = 0;
  int lat, moves, loads, pzc, sels, first, last, dirbad;
  logic er, rdy_at_done, seen;
  logic [NL-1:0] any_act, other;
  always #5 clk = ~clk;
  ddr_lane_dly_ctrl u_dut (
    .FAB_CLK(clk), .RESET(rst), .CMD_VALID(cv), .CMD_READY(rdy), .CMD_LANE(clane),
    .CMD_OP(cop), .CMD_DIR(cdir), .CMD_TAPS(ctaps), .DELAY_LINE_SEL(sel),
    .DELAY_LINE_LOAD(ld), .DELAY_LINE_DIRECTION(dr), .DELAY_LINE_MOVE(mv),
    .HS_IO_CLK_PAUSE(pz), .DELAY_LINE_OUT_OF_RANGE(oor), .DONE(done), .ERR(err)
`ifdef DDR_DLY_TAP_READBACK_EN
    , .QUERY_LANE(ql), .TAP_POS(tp)
`endif
  );
  ddr_lane_dly_ctrl #(.NUM_LANES(3)) u_dut3 (
    .FAB_CLK(clk), .RESET(rst), .CMD_VALID(cv3), .CMD_READY(rdy3), .CMD_LANE(clane3),
    .CMD_OP(2'b00), .CMD_DIR(1'b1), .CMD_TAPS(8'd3), .DELAY_LINE_SEL(sel3),
    .DELAY_LINE_LOAD(ld3), .DELAY_LINE_DIRECTION(dr3), .DELAY_LINE_MOVE(mv3),
    .HS_IO_CLK_PAUSE(pz3), .DELAY_LINE_OUT_OF_RANGE(3'b000), .DONE(done3), .ERR(err3)
`ifdef DDR_DLY_TAP_READBACK_EN
    , .QUERY_LANE(ql3), .TAP_POS(tp3)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // issue one command, then observe on falling edges until DONE (cycle 1 = first cycle after accept)
  task automatic run(input logic [1:0] lane, input logic [1:0] op, input logic dir,
                     input logic [7:0] taps, input int oor_n);
    logic [NL-1:0] act;
    @(negedge clk);
    cv = 1'b1; clane = lane; cop = op; cdir = dir; ctaps = taps;
    @(negedge clk);
    cv = 1'b0;
    lat = -1; moves = 0; loads = 0; pzc = 0; sels = 0; first = -1; last = -1; dirbad = 0;
    er = 1'b0; rdy_at_done = 1'b1; any_act = '0; other = '0;
    for (int c = 1; c <= 300; c++) begin
      act = sel | ld | dr | mv | pz;
      any_act |= act;
      other |= act & ~(NL'(1) << lane);
      if (mv[lane]) begin
        moves++;
        if (first < 0) first = c;
        last = c;
        if (moves == oor_n) oor[lane] = 1'b1;
      end
      loads += int'(ld[lane]);
      pzc += int'(pz[lane]);
      sels += int'(sel[lane]);
      if (sel[lane] && dr[lane] !== dir) dirbad++;
      if (done) begin
        lat = c; er = err; rdy_at_done = rdy;
        break;
      end
      @(negedge clk);
    end
    oor = '0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {sel, ld, dr, mv, pz, done, err}, 0);
    chk("rst_rdy", rdy, 1);
    run(2'd2, 2'b00, 1'b1, 8'd3, 0);
    chk("mv3_lat", lat, 12);
    chk("mv3_pulses", moves, 3);
    chk("mv3_first", first, 4);
    chk("mv3_last", last, 8);
    chk("mv3_pause", pzc, 11);
    chk("mv3_sel", sels, 7);
    chk("mv3_dir", dirbad, 0);
    chk("mv3_err", er, 0);
    chk("mv3_other", other, 0);
    chk("mv3_rdy_at_done", rdy_at_done, 0);
    @(negedge clk);
    chk("mv3_rdy_after", rdy, 1);
    chk("mv3_idle_outs", {sel, mv, pz, done}, 0);
`ifdef DDR_DLY_TAP_READBACK_EN
    ql = 2'd2;
    @(negedge clk);
    chk("mv3_tap_pos", tp, 8'd3);
`endif
    run(2'd0, 2'b01, 1'b0, 8'hFE, 0);
    chk("ld_lat", lat, 7);
    chk("ld_pulses", loads, 1);
    chk("ld_moves", moves, 0);
    chk("ld_pause", pzc, 6);
    chk("ld_sel", sels, 2);
    chk("ld_err", er, 0);
    run(2'd0, 2'b00, 1'b1, 8'd4, 0);
    chk("sat_lat", lat, 14);
    chk("sat_pulses", moves, 4);
    chk("sat_err", er, 0);
`ifdef DDR_DLY_TAP_READBACK_EN
    @(negedge clk);
    ql = 2'd0;
    @(negedge clk);
    chk("sat_tap_pos", tp, 8'hFF);
`endif
    run(2'd1, 2'b00, 1'b0, 8'd10, 2);
    chk("oor_pulses", moves, 2);
    chk("oor_lat", lat, 10);
    chk("oor_pause", pzc, 9);
    chk("oor_err", er, 1);
    chk("oor_other", other, 0);
    @(negedge clk);
    chk("oor_released", {sel, pz, mv}, 0);
    run(2'd0, 2'b11, 1'b0, 8'd5, 0);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_err", er, 1);
    chk("rsvd_quiet", any_act, 0);
    run(2'd3, 2'b10, 1'b0, 8'd0, 0);
    chk("query_lat", lat, 1);
    chk("query_err", er, !RB);
    chk("query_quiet", any_act, 0);
    run(2'd3, 2'b00, 1'b1, 8'd0, 0);
    chk("zero_lat", lat, 1);
    chk("zero_err", er, 0);
    chk("zero_quiet", any_act, 0);
    @(negedge clk);
    cv = 1'b1; clane = 2'd0; cop = 2'b00; cdir = 1'b1; ctaps = 8'd0;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_rdy1", rdy, 0);
    @(negedge clk);
    chk("b2b_gap", {done, rdy}, 2'b01);
    @(negedge clk);
    chk("b2b_done2", done, 1);
    cv = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {done, rdy}, 2'b01);
    cv3 = 1'b1; clane3 = 2'd3;
    @(negedge clk);
    cv3 = 1'b0;
    chk("badlane_done", {done3, err3}, 2'b11);
    chk("badlane_quiet", {sel3, ld3, dr3, mv3, pz3}, 0);
    @(negedge clk);
    chk("badlane_after", {done3, rdy3, sel3, mv3, pz3}, 11'b01_000_000_000);
    cv = 1'b1; clane = 2'd2; cop = 2'b00; cdir = 1'b1; ctaps = 8'd5;
    @(negedge clk);
    cv = 1'b0;
    for (int c = 0; c < 20 && !mv[2]; c++) @(negedge clk);
    chk("rst_mid_seen", mv[2], 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_drop", {sel, ld, dr, mv, pz, done, err}, 0);
    chk("rst_mid_rdy", rdy, 1);
`ifdef DDR_DLY_TAP_READBACK_EN
    chk("rst_mid_tap_pos", tp, 0);
`endif
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= done;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= done | (|pz) | (|sel) | (|mv);
    end
    chk("rst_mid_no_done", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
